// File: rtl/bti_pkg.sv
// bti_pkg: shared definitions for the BTI two-requester arbiter.
//   req_id_t       - requester identity stored in the in-order ID queue
//   OSTD_DEPTH_DEF - default maximum number of outstanding downstream requests
//   BTI_TW         - transaction ID width carried in request/response packets
package bti_pkg;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_t;

  localparam int OSTD_DEPTH_DEF = 4;
  localparam int BTI_TW         = 4;

endpackage

// File: rtl/bti_if.sv
// BTI request/response channel interfaces.
//   bti_req_if_t : vld/rdy handshake carrying pkt {addr, tid}
//   bti_rsp_if_t : vld/rdy handshake carrying pkt {data, tid, ok}
//   modport mst drives vld and the packet, slv drives rdy.
interface bti_req_if_t #(
  parameter int AW = 32
) ();
  logic                      vld;
  logic                      rdy;
  logic [AW-1:0]             addr;
  logic [bti_pkg::BTI_TW-1:0] tid;

  modport mst (output vld, output addr, output tid, input rdy);
  modport slv (input vld, input addr, input tid, output rdy);
endinterface

interface bti_rsp_if_t #(
  parameter int DW = 32
) ();
  logic                      vld;
  logic                      rdy;
  logic [DW-1:0]             data;
  logic [bti_pkg::BTI_TW-1:0] tid;
  logic                      ok;

  modport mst (output vld, output data, output tid, output ok, input rdy);
  modport slv (input vld, input data, input tid, input ok, output rdy);
endinterface

// File: rtl/bti_ord_fifo.sv
// bti_ord_fifo: in-order queue of requester IDs for outstanding transactions.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : enqueue din (caller guarantees not full)
//   pop        : dequeue head (caller guarantees not empty)
//   full/empty : occupancy flags, head : oldest entry
module bti_ord_fifo #(
  parameter int DW    = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

endmodule

// File: rtl/bti_arb2.sv
// bti_arb2: round-robin arbiter sharing one BTI slave between two requesters.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bti_req_slv0/1 : request channels from requester 0 (ifetch) / 1 (load)
//   bti_rsp_mst0/1 : response channels back to requester 0 / 1
//   bti_req_mst    : shared request channel to the slave (combinational path)
//   bti_rsp_slv    : shared response channel from the slave
// Responses return in order; an ID queue remembers which requester owns each
// outstanding request so responses can be steered back.
module bti_arb2 import bti_pkg::*; #(
  parameter int BTI_AW     = 32,
  parameter int BTI_DW     = 32,
  parameter int OSTD_DEPTH = OSTD_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  bti_req_if_t.slv   bti_req_slv0,
  bti_rsp_if_t.mst   bti_rsp_mst0,
  bti_req_if_t.slv   bti_req_slv1,
  bti_rsp_if_t.mst   bti_rsp_mst1,
  bti_req_if_t.mst   bti_req_mst,
  bti_rsp_if_t.slv   bti_rsp_slv
);

  req_id_t             prio;
  req_id_t             gnt;
  req_id_t             lock_id;
  req_id_t             head_id;
  logic                lock;
  logic                gnt_vld;
  logic [BTI_AW-1:0]   gnt_addr;
  logic [BTI_DW-1:0]   rsp_data;
  logic                req_hs;
  logic                ord_full;
  logic                ord_empty;
  logic                ord_pop;
  logic [0:0]          ord_head;
  logic                stray_rsp;

  // A request shown downstream but not yet accepted keeps its grant so the
  // packet stays stable across slave back-pressure.
  always_comb begin
    gnt = REQ_0;
    if (lock)                                   gnt = lock_id;
    else if (bti_req_slv0.vld && bti_req_slv1.vld) gnt = prio;
    else if (bti_req_slv1.vld)                  gnt = REQ_1;
  end

  assign gnt_vld  = (gnt == REQ_1) ? bti_req_slv1.vld  : bti_req_slv0.vld;
  assign gnt_addr = (gnt == REQ_1) ? bti_req_slv1.addr : bti_req_slv0.addr;

  assign bti_req_mst.vld  = rst_n & gnt_vld & ~ord_full;
  assign bti_req_mst.addr = gnt_addr;
  assign bti_req_mst.tid  = (gnt == REQ_1) ? bti_req_slv1.tid : bti_req_slv0.tid;

  assign bti_req_slv0.rdy = rst_n & gnt_vld & (gnt == REQ_0) & bti_req_mst.rdy & ~ord_full;
  assign bti_req_slv1.rdy = rst_n & gnt_vld & (gnt == REQ_1) & bti_req_mst.rdy & ~ord_full;

  assign req_hs = bti_req_mst.vld & bti_req_mst.rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= REQ_0;
      lock    <= 1'b0;
      lock_id <= REQ_0;
    end else if (req_hs) begin
      prio <= (gnt == REQ_0) ? REQ_1 : REQ_0;
      lock <= 1'b0;
    end else if (bti_req_mst.vld) begin
      lock    <= 1'b1;
      lock_id <= gnt;
    end
  end

  bti_ord_fifo #(
    .DW    (1),
    .DEPTH (OSTD_DEPTH)
  ) u_ordq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_hs),
    .pop   (ord_pop),
    .din   (gnt),
    .full  (ord_full),
    .empty (ord_empty),
    .head  (ord_head)
  );

  assign head_id  = req_id_t'(ord_head);
  assign rsp_data = bti_rsp_slv.data;

  assign bti_rsp_mst0.vld  = rst_n & bti_rsp_slv.vld & ~ord_empty & (head_id == REQ_0);
  assign bti_rsp_mst0.data = rsp_data;
  assign bti_rsp_mst0.tid  = bti_rsp_slv.tid;
  assign bti_rsp_mst0.ok   = bti_rsp_slv.ok;

  assign bti_rsp_mst1.vld  = rst_n & bti_rsp_slv.vld & ~ord_empty & (head_id == REQ_1);
  assign bti_rsp_mst1.data = rsp_data;
  assign bti_rsp_mst1.tid  = bti_rsp_slv.tid;
  assign bti_rsp_mst1.ok   = bti_rsp_slv.ok;

  // With nothing outstanding the slave response has no owner: accept and drop
  // it so the slave cannot deadlock.
  assign bti_rsp_slv.rdy = rst_n & (ord_empty |
                           ((head_id == REQ_1) ? bti_rsp_mst1.rdy : bti_rsp_mst0.rdy));

  assign ord_pop   = bti_rsp_slv.vld & bti_rsp_slv.rdy & ~ord_empty;
  assign stray_rsp = rst_n & bti_rsp_slv.vld & ord_empty;

  always @(posedge clk) begin
    if (rst_n) begin
      stray_chk: assert (!stray_rsp)
        else $warning("bti_arb2: response with no outstanding request dropped");
    end
  end

endmodule

// File: doc/bti_arb2.md
BTI_ARB2 -- requirements
Module: bti_arb2

Interface
REQ-001 SHALL have parameter BTI_AW, default 32, BTI address width.
REQ-002 SHALL have parameter BTI_DW, default 32, BTI data width.
REQ-003 SHALL have parameter OSTD_DEPTH, default 4, maximum outstanding downstream requests; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port bti_req_slv0, bti_req_if_t.slv: requester 0 (instruction fetch) request channel.
REQ-007 SHALL have port bti_rsp_mst0, bti_rsp_if_t.mst: requester 0 response channel.
REQ-008 SHALL have port bti_req_slv1, bti_req_if_t.slv: requester 1 (data load) request channel.
REQ-009 SHALL have port bti_rsp_mst1, bti_rsp_if_t.mst: requester 1 response channel.
REQ-010 SHALL have port bti_req_mst, bti_req_if_t.mst: shared request channel to the bti_rom slave.
REQ-011 SHALL have port bti_rsp_slv, bti_rsp_if_t.slv: shared response channel from the bti_rom slave.

Function
REQ-012 SHALL arbitrate requests round-robin between requesters 0 and 1, with grant priority held in register prio.
REQ-013 SHALL grant the sole valid requester, or the prio requester when both are valid.
REQ-014 SHALL, once a granted request is presented downstream without handshake, hold that grant (lock) until the downstream handshake completes, regardless of the other requester.
REQ-015 SHALL drive bti_req_mst.vld = granted vld AND NOT ordq_full, pass the granted pkt (addr, tid) unmodified, and assert only the granted requester's rdy = bti_req_mst.rdy AND NOT ordq_full; the non-granted rdy SHALL be 0.
REQ-016 SHALL add zero cycles of request latency (combinational path, no request-data registering).
REQ-017 SHALL, on each downstream request handshake, push the granted requester ID into an in-order ID queue (ordq) and set prio to the other requester.
REQ-018 SHALL block new downstream requests while ordq holds OSTD_DEPTH entries, even if a pop occurs in the same cycle.
REQ-019 SHALL route bti_rsp_slv (vld, pkt data/tid/ok unmodified) only to the requester at ordq head; bti_rsp_slv.rdy SHALL equal that requester's rsp rdy; the other requester's rsp vld SHALL be 0.
REQ-020 SHALL pop ordq on each bti_rsp_slv handshake; simultaneous push and pop SHALL leave the count unchanged.
REQ-021 SHALL, when bti_rsp_slv.vld arrives with ordq empty, drive bti_rsp_slv.rdy = 1, drop the response, and fire a simulation assertion.
REQ-022 SHALL implement ordq with read/write pointers of clog2(OSTD_DEPTH) bits wrapping modulo OSTD_DEPTH and a count of clog2(OSTD_DEPTH)+1 bits.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear ordq pointers and count, clear lock, and set prio to requester 0.
REQ-024 SHALL hold all vld/rdy outputs at 0 while rst_n is low; in-flight transactions SHALL be discarded and not replayed.

Structure
REQ-025 SHALL place the requester-ID typedef (1 bit) and the OSTD_DEPTH default in shared package bti_pkg.
REQ-026 SHALL implement ordq as sub-module bti_ord_fifo (parameters DW, DEPTH; ports push/pop/full/empty/head), with arbitration in bti_arb2.

Verification
REQ-027 SHALL cover: only requester 0 sends addr 0x100 -> granted same cycle, response data routed to rsp_mst0 only.
REQ-028 SHALL cover: both requesters valid every cycle with downstream always ready -> grants alternate 0,1,0,1; each requester receives 50 percent +/- 1 of responses.
REQ-029 SHALL cover: requester 1 granted, bti_req_mst.rdy low 3 cycles while requester 0 raises vld -> grant stays 1, pkt stable, then requester 0 is granted next.
REQ-030 SHALL cover: response channel stalled with OSTD_DEPTH=4 and 4 issued -> 5th request vld downstream = 0 until one response pops.
REQ-031 SHALL cover: ordq holding 0,1,1,0 with responses returned in order -> data reaches rsp_mst0, rsp_mst1, rsp_mst1, rsp_mst0; rsp_mst1 rdy low stalls rsp_slv.rdy.
REQ-032 SHALL cover: rst_n asserted mid-transfer with 2 outstanding -> count 0 and prio 0 immediately; post-reset stray response is dropped and the assertion fires.
